// File: rtl/wb_pkg.sv
// Shared widths, register constants and the queued-result entry layout
// for the writeback arbiter.
package wb_pkg;

  localparam int                DATA_W       = 32;
  localparam int                REG_AW       = 5;
  localparam logic [REG_AW-1:0] REG_STATUS   = 5'd30;
  localparam logic [DATA_W-1:0] EXC_CODE_DEF = 32'd1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              exc;
  } res_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO exposing every slot and a per-slot "still valid after this cycle's pop" vector.
// Zero-latency head; push when full is dropped unless a pop frees the slot in the same cycle.
module wb_fifo #(
  parameter int  W     = 8,
  parameter int  DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [W-1:0]            push_dat_i,
  input  logic                    pop_i,
  output logic [W-1:0]            head_dat_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [CW-1:0]           count_o,
  output logic [DEPTH-1:0]        live_vld_o,
  output logic [DEPTH-1:0][W-1:0] ent_dat_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
  assign head_dat_o = mem_q[rd_q];
  assign ent_dat_o  = mem_q;

  always_comb begin
    do_pop     = pop_i && !empty_o;
    do_push    = push_i && (!full_o || do_pop);
    vld_d      = vld_q;
    live_vld_o = vld_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    if (do_pop) begin
      vld_d[rd_q]      = 1'b0;
      live_vld_o[rd_q] = 1'b0;
      rd_d             = nxt(rd_q);
    end
    if (do_push) begin
      vld_d[wr_q] = 1'b1;
      wr_d        = nxt(wr_q);
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile writeback arbiter: pipeline > queued mult/div result > bypassed md_done; writes registered 1 cycle after selection.
// Pipeline never stalls; mult/div issue is throttled by md_ready. WB_EXC_EN adds md_exception (redirects to the status reg).
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int                Q_DEPTH  = 2,
  parameter logic [DATA_W-1:0] EXC_CODE = EXC_CODE_DEF
) (
  input  logic                 clock,
  input  logic                 ctrl_reset,
  input  logic                 pipe_valid,
  input  logic [REG_AW-1:0]    pipe_rd,
  input  logic [DATA_W-1:0]    pipe_data,
  input  logic                 md_issue,
  input  logic [REG_AW-1:0]    md_issue_rd,
  input  logic                 md_done,
  input  logic [DATA_W-1:0]    md_result,
`ifdef WB_EXC_EN
  input  logic                 md_exception,
`endif
  output logic                 ctrl_writeEnable,
  output logic [REG_AW-1:0]    ctrl_writeReg,
  output logic [DATA_W-1:0]    data_writeReg,
  output logic [2**REG_AW-1:0] busy_mask,
  output logic                 md_ready,
  output logic                 err_sticky
);

  localparam int CW  = $clog2(Q_DEPTH + 1);
  localparam int OCW = CW + 1;
  localparam int RW  = $bits(res_t);

  logic                            pipe_wr, issue_ok, done_ok, done_exc;
  logic                            res_push, res_pop, sel_vld;
  logic                            tag_full, tag_empty, res_full, res_empty;
  logic [REG_AW-1:0]               tag_head;
  logic [CW-1:0]                   tag_cnt, res_cnt;
  logic [OCW-1:0]                  out_cnt;
  logic [Q_DEPTH-1:0]              tag_live, res_live;
  logic [Q_DEPTH-1:0][REG_AW-1:0]  tag_ent;
  logic [Q_DEPTH-1:0][RW-1:0]      res_ent;
  logic [RW-1:0]                   res_head_raw;
  res_t                            done_ent, res_head, sel_ent;

  logic                            we_q, we_d;
  logic [REG_AW-1:0]               wreg_q, wreg_d;
  logic [DATA_W-1:0]               wdat_q, wdat_d;
  logic                            err_q, err_d;

`ifdef WB_EXC_EN
  assign done_exc = md_exception;
`else
  assign done_exc = 1'b0;
`endif

  // Ready comes from registered occupancy only, so a same-cycle md_done never frees a slot for an issue.
  assign out_cnt  = {1'b0, tag_cnt} + {1'b0, res_cnt};
  assign md_ready = (out_cnt < OCW'(Q_DEPTH));
  assign issue_ok = md_issue && md_ready && !tag_full;
  assign done_ok  = md_done && !tag_empty;
  assign pipe_wr  = pipe_valid && (pipe_rd != '0);
  assign done_ent = '{rd: tag_head, data: md_result, exc: done_exc};
  assign res_head = res_t'(res_head_raw);

  wb_fifo #(.W(REG_AW), .DEPTH(Q_DEPTH)) u_tag_fifo (
    .clk_i      (clock),
    .rst_i      (ctrl_reset),
    .push_i     (issue_ok),
    .push_dat_i (md_issue_rd),
    .pop_i      (done_ok),
    .head_dat_o (tag_head),
    .full_o     (tag_full),
    .empty_o    (tag_empty),
    .count_o    (tag_cnt),
    .live_vld_o (tag_live),
    .ent_dat_o  (tag_ent)
  );

  wb_fifo #(.W(RW), .DEPTH(Q_DEPTH)) u_res_fifo (
    .clk_i      (clock),
    .rst_i      (ctrl_reset),
    .push_i     (res_push),
    .push_dat_i (done_ent),
    .pop_i      (res_pop),
    .head_dat_o (res_head_raw),
    .full_o     (res_full),
    .empty_o    (res_empty),
    .count_o    (res_cnt),
    .live_vld_o (res_live),
    .ent_dat_o  (res_ent)
  );

  always_comb begin
    res_push = 1'b0;
    res_pop  = 1'b0;
    sel_vld  = 1'b0;
    sel_ent  = '0;
    if (pipe_wr) begin
      sel_vld  = 1'b1;
      sel_ent  = '{rd: pipe_rd, data: pipe_data, exc: 1'b0};
      res_push = done_ok && !res_full;
    end else if (!res_empty) begin
      res_pop  = 1'b1;
      sel_vld  = 1'b1;
      sel_ent  = res_head;
      res_push = done_ok && !res_full;
    end else if (done_ok) begin
      sel_vld  = 1'b1;
      sel_ent  = done_ent;
    end

    // rd==0 entries still burn their slot but never raise the write enable.
    we_d   = 1'b0;
    wreg_d = wreg_q;
    wdat_d = wdat_q;
    if (sel_vld) begin
      if (sel_ent.exc) begin
        we_d   = 1'b1;
        wreg_d = REG_STATUS;
        wdat_d = EXC_CODE;
      end else if (sel_ent.rd != '0) begin
        we_d   = 1'b1;
        wreg_d = sel_ent.rd;
        wdat_d = sel_ent.data;
      end
    end

    err_d = err_q || (md_issue && !md_ready) || (md_done && tag_empty);
  end

  // Entries selected this cycle are already excluded by live_vld; a done that
  // moves into the result FIFO keeps its register reserved.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      if (tag_live[i]) busy_mask[tag_ent[i]] = 1'b1;
      if (res_live[i]) busy_mask[res_ent[i][RW-1 -: REG_AW]] = 1'b1;
    end
    if (res_push) busy_mask[tag_head] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      we_q   <= 1'b0;
      wreg_q <= '0;
      wdat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      wreg_q <= wreg_d;
      wdat_q <= wdat_d;
      err_q  <= err_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdat_q;
  assign err_sticky       = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboarded bench for wb_arbiter: expected regfile writes (reg, data, arrival cycle) are queued
// by the stimulus and retired by a negedge monitor; status outputs are checked directly.
module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_done;
  logic [31:0] md_result;
`ifdef WB_EXC_EN
  logic        md_exception;
`endif
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] busy_mask;
  logic        md_ready;
  logic        err_sticky;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  wb_arbiter #(.Q_DEPTH(2)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .pipe_valid       (pipe_valid),
    .pipe_rd          (pipe_rd),
    .pipe_data        (pipe_data),
    .md_issue         (md_issue),
    .md_issue_rd      (md_issue_rd),
    .md_done          (md_done),
    .md_result        (md_result),
`ifdef WB_EXC_EN
    .md_exception     (md_exception),
`endif
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .busy_mask        (busy_mask),
    .md_ready         (md_ready),
    .err_sticky       (err_sticky)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expw(input logic [4:0] r, input logic [31:0] d, input int lat);
    q.push_back('{r: r, d: d, c: cyc + lat});
  endtask

  exp_t e;
  always @(negedge clock) begin
    if (ctrl_writeEnable === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got reg %0d data %0h at cycle %0d, expected no write",
                 ctrl_writeReg, data_writeReg, cyc);
      end else begin
        e = q.pop_front();
        if (ctrl_writeReg !== e.r || data_writeReg !== e.d || cyc != e.c) begin
          errors++;
          $display("FAIL write: got reg %0d data %0h cycle %0d expected reg %0d data %0h cycle %0d",
                   ctrl_writeReg, data_writeReg, cyc, e.r, e.d, e.c);
        end
      end
    end
  end

  initial begin
    ctrl_reset  = 1'b1;
    pipe_valid  = 1'b0;
    pipe_rd     = '0;
    pipe_data   = '0;
    md_issue    = 1'b0;
    md_issue_rd = '0;
    md_done     = 1'b0;
    md_result   = '0;
`ifdef WB_EXC_EN
    md_exception = 1'b0;
`endif
    tick();
    tick();
    ctrl_reset = 1'b0;
    chk("rst_we",    ctrl_writeEnable, 0);
    chk("rst_reg",   ctrl_writeReg,    0);
    chk("rst_data",  data_writeReg,    0);
    chk("rst_busy",  busy_mask,        0);
    chk("rst_ready", md_ready,         1);
    chk("rst_err",   err_sticky,       0);

    // Plain pipeline write
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hAA;
    expw(5'd5, 32'hAA, 1);
    tick();
    pipe_valid = 1'b0;
    chk("t1_busy", busy_mask, 0);

    // Single mult/div op, bypassed
    md_issue = 1'b1; md_issue_rd = 5'd7;
    tick();
    md_issue = 1'b0;
    chk("t2_busy_a", busy_mask, 32'h80);
    tick();
    chk("t2_busy_b", busy_mask, 32'h80);
    tick();
    md_done = 1'b1; md_result = 32'h1234;
    expw(5'd7, 32'h1234, 1);
    #1 chk("t2_busy_sel", busy_mask, 0);
    tick();
    md_done = 1'b0;

    // Collision: pipeline wins, result queued and written next cycle
    md_issue = 1'b1; md_issue_rd = 5'd7;
    tick();
    md_issue = 1'b0;
    tick();
    md_done = 1'b1; md_result = 32'h77;
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
    expw(5'd3, 32'h33, 1);
    expw(5'd7, 32'h77, 2);
    #1 chk("t3_busy_queued", busy_mask, 32'h80);
    tick();
    md_done = 1'b0; pipe_valid = 1'b0;
    #1 chk("t3_busy_sel", busy_mask, 0);
    tick();

    // pipe_rd==0 does not block a bypass; an rd==0 result writes nothing
    md_issue = 1'b1; md_issue_rd = 5'd12;
    tick();
    md_issue = 1'b0;
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEAD;
    md_done = 1'b1; md_result = 32'hC;
    expw(5'd12, 32'hC, 1);
    tick();
    pipe_valid = 1'b0; md_done = 1'b0;
    md_issue = 1'b1; md_issue_rd = 5'd0;
    tick();
    md_issue = 1'b0;
    md_done = 1'b1; md_result = 32'h55;
    tick();
    md_done = 1'b0;
    chk("rd0_we",    ctrl_writeEnable, 0);
    chk("rd0_hold_reg",  ctrl_writeReg, 12);
    chk("rd0_hold_data", data_writeReg, 32'hC);
    chk("rd0_ready", md_ready, 1);

    // Two ops to rd 4 fill the queue; third issue rejected
    md_issue = 1'b1; md_issue_rd = 5'd4;
    tick();
    tick();
    chk("t4_ready_full", md_ready, 0);
    chk("t4_err_before", err_sticky, 0);
    chk("t4_busy", busy_mask, 32'h10);
    tick();
    md_issue = 1'b0;
    chk("t4_err_set", err_sticky, 1);
    chk("t4_ready_still", md_ready, 0);
    md_done = 1'b1; md_result = 32'h41;
    expw(5'd4, 32'h41, 1);
    #1 chk("t4_busy_one_left", busy_mask, 32'h10);
    tick();
    md_result = 32'h42;
    expw(5'd4, 32'h42, 1);
    chk("t4_ready_back", md_ready, 1);
    #1 chk("t4_busy_last_sel", busy_mask, 0);
    tick();
    md_done = 1'b0;
    chk("t4_busy_end", busy_mask, 0);

    // md_done with nothing outstanding
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    chk("t5_err_cleared", err_sticky, 0);
    md_done = 1'b1; md_result = 32'hBAD;
    tick();
    md_done = 1'b0;
    chk("t5_err_set", err_sticky, 1);
    chk("t5_no_write", ctrl_writeEnable, 0);

    // Issue and done together on a full queue: issue rejected
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    md_issue = 1'b1; md_issue_rd = 5'd13;
    tick();
    md_issue_rd = 5'd14;
    tick();
    md_issue_rd = 5'd15;
    md_done = 1'b1; md_result = 32'hD1;
    expw(5'd13, 32'hD1, 1);
    tick();
    md_issue = 1'b0;
    chk("t6_err", err_sticky, 1);
    md_result = 32'hD2;
    expw(5'd14, 32'hD2, 1);
    tick();
    md_done = 1'b0;
    chk("t6_busy_no15", busy_mask, 0);
    chk("t6_ready", md_ready, 1);

    // Reset with two results queued behind pipeline traffic
    md_issue = 1'b1; md_issue_rd = 5'd10;
    tick();
    md_issue_rd = 5'd11;
    tick();
    md_issue = 1'b0;
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h101;
    md_done = 1'b1; md_result = 32'hA;
    expw(5'd1, 32'h101, 1);
    tick();
    pipe_rd = 5'd2; pipe_data = 32'h202; md_result = 32'hB;
    expw(5'd2, 32'h202, 1);
    tick();
    pipe_valid = 1'b0; md_done = 1'b0;
    chk("t7_busy_queued", busy_mask, 32'hC00);
    chk("t7_ready_full", md_ready, 0);
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    chk("t7_busy_rst", busy_mask, 0);
    chk("t7_ready_rst", md_ready, 1);
    chk("t7_we_rst", ctrl_writeEnable, 0);
    tick();
    tick();
    chk("t7_we_after", ctrl_writeEnable, 0);
    chk("t7_busy_after", busy_mask, 0);

`ifdef WB_EXC_EN
    // Excepting result goes to the status register with the fixed code
    md_issue = 1'b1; md_issue_rd = 5'd9;
    tick();
    md_issue = 1'b0;
    md_done = 1'b1; md_exception = 1'b1; md_result = 32'h999;
    expw(5'd30, 32'h1, 1);
    #1 chk("exc_busy_sel", busy_mask, 0);
    tick();
    md_done = 1'b0; md_exception = 1'b0;
    chk("exc_busy_end", busy_mask, 0);
`endif

    tick();
    tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
